// File: rtl/preg_free_list.sv
// Physical-register free list: a circular FIFO of free tags feeding rename.
// Reset preloads tags NUM_AREGS..NUM_PREGS-1; tag 0 is permanently bound to x0.
module preg_free_list #(
   parameter int NUM_PREGS = 64,
   parameter int NUM_AREGS = 32,
   localparam int TAG_W = $clog2(NUM_PREGS),
   localparam int DEPTH = NUM_PREGS - NUM_AREGS,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_req,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             alloc_valid,
   output logic             stall,
   input  logic             free_en,
   input  logic [TAG_W-1:0] free_tag,
   output logic [CNT_W-1:0] free_count,
   output logic             overflow_err
);

   logic [TAG_W-1:0] mem_q [DEPTH];
   logic [TAG_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   logic grant;
   logic full;
   logic tag_zero;
   logic free_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      grant    = alloc_req && (count_q != '0);
      full     = (count_q == CNT_W'(DEPTH));
      tag_zero = (free_tag == '0);
      // A full list still accepts a free when a grant frees a slot on the same edge.
      free_ok  = free_en && !tag_zero && (!full || grant);

      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      if (grant) begin
         head_d = ptr_inc(head_q);
      end
      if (free_ok) begin
         mem_d[tail_q] = free_tag;
         tail_d        = ptr_inc(tail_q);
      end

      case ({free_ok, grant})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      err_d = err_q || (free_en && (tag_zero || (full && !grant)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= TAG_W'(NUM_AREGS + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_W'(DEPTH);
         err_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Head lookahead is combinational so rename sees the tag in the request cycle.
   assign alloc_tag    = mem_q[head_q];
   assign alloc_valid  = (count_q != '0);
   assign stall        = alloc_req && (count_q == '0);
   assign free_count   = count_q;
   assign overflow_err = err_q;

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 Parameter NUM_PREGS, default 64, total physical registers; tag width TAG_W = 6.
REQ-002 Parameter NUM_AREGS, default 32, architectural registers; list depth DEPTH = NUM_PREGS - NUM_AREGS = 32.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 alloc_req  input  1  rename requests a new destination tag this cycle.
REQ-006 alloc_tag  output  6  tag at list head; valid when alloc_valid=1.
REQ-007 alloc_valid  output  1  list non-empty.
REQ-008 stall  output  1  alloc_req=1 while list empty; rename/fetch must hold.
REQ-009 free_en  input  1  commit returns a tag this cycle.
REQ-010 free_tag  input  6  tag being returned.
REQ-011 free_count  output  6  entries currently in list, 0..32.
REQ-012 overflow_err  output  1  sticky; a free was dropped because the list was full, or free_tag was 0.

Function
REQ-013 Storage: circular buffer of DEPTH 6-bit entries, 5-bit head and tail pointers, 6-bit count.
REQ-014 alloc_tag = entry[head], combinational; zero-latency lookahead, no pipeline stage.
REQ-015 alloc_valid = (count != 0); stall = alloc_req & (count == 0), combinational.
REQ-016 Grant: alloc_req=1 and count>0 at rising edge -> head <= head+1 mod 32; the tag shown during that cycle is consumed.
REQ-017 Free: free_en=1, free_tag!=0 and (count<32 or grant same edge) -> entry[tail] <= free_tag, tail <= tail+1 mod 32.
REQ-018 Count update per edge: +1 free only, -1 grant only, unchanged for both or neither.
REQ-019 Empty plus simultaneous alloc and free: no bypass; the alloc stalls, the free is written, and alloc_valid rises next cycle with the freed tag.
REQ-020 Full plus simultaneous alloc and free: both accepted; count stays 32.
REQ-021 Full and free without alloc: free dropped, pointers and count unchanged, overflow_err <= 1.
REQ-022 free_en with free_tag==0 (p0 permanently bound to x0): ignored and overflow_err <= 1.
REQ-023 alloc_req with count==0: no state change.
REQ-024 Pointer wrap 31->0 is seamless; FIFO order is preserved across wrap.
REQ-025 No duplicate-tag detection beyond REQ-022; the commit logic guarantees uniqueness.
REQ-026 Expected size 120-250 lines of RTL; no latches; all state in one clocked process with asynchronous reset.

Reset
REQ-027 On rst=1 (asynchronous, any cycle, including mid-operation), entry[i] <= NUM_AREGS+i (tags 32..63), head=0, tail=0, count=32, overflow_err=0.
REQ-028 After reset: alloc_tag=32, alloc_valid=1, stall=0, free_count=32.
REQ-029 Operations are suppressed while rst=1; the first grant can occur on the first rising edge after rst deasserts.

Verification
REQ-030 Reset, then alloc_req=1 for 32 cycles -> alloc_tag sequence 32,33,...,63; count then 0, alloc_valid=0, stall=1 while alloc_req stays high.
REQ-031 From empty, free_en with free_tag=5 and alloc_req=1 in the same cycle -> stall=1 that cycle; next cycle alloc_tag=5, count=1.
REQ-032 From full (reset state), free_en with free_tag=7 and no alloc -> count stays 32, overflow_err=1 and stays set until rst.
REQ-033 From full, alloc and free(tag 9) together -> count 32, alloc_tag advances to 33, and tag 9 is returned after tags 33..63.
REQ-034 Wrap test: 40 cycles of interleaved alloc and free of distinct tags -> FIFO order exact across the 31->0 pointer wrap; count matches the scoreboard every cycle.
REQ-035 Assert rst asynchronously mid-stream (between edges) -> outputs return to REQ-028 values immediately, without waiting for a clock edge.
